// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec_pkg
// Description : Shared definitions for the dec_pipe decrement engine: mode
//               encodings and the {borrow, result} arithmetic function.
//               Both the datapath and its reference model use the function.
// Revision    : 1.0 - initial release
// ============================================================================
package dec_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest operand the shared function handles; narrower callers zero-extend
  // their operands and pass their real width.
  localparam int unsigned DEC_MAX_W = 64;

  // Returns {borrow, result}. Only the low 'width' bits of the result are
  // meaningful; the bits above are forced to zero.
  function automatic logic [DEC_MAX_W:0] dec_calc(
    input logic [DEC_MAX_W-1:0] data,
    input logic [DEC_MAX_W-1:0] step,
    input int unsigned          width,
    input logic                 mode
  );
    logic [DEC_MAX_W-1:0] mask;
    logic [DEC_MAX_W-1:0] diff;
    logic                 borrow;
    mask   = (width >= DEC_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    borrow = (data & mask) < (step & mask);
    diff   = (data - step) & mask;
    if ((mode == MODE_SAT) && borrow) begin
      diff = '0;
    end
    return {borrow, diff};
  endfunction

endpackage : dec_pkg
`default_nettype wire

// File: rtl/dec_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : dec_fifo2
// Description : Two-entry FIFO with registered occupancy count.
// Ports       : clk, rst_n (async active-low)
//               push/push_data  - write request and data (ignored when full)
//               pop             - read request (ignored when empty)
//               pop_data        - oldest entry, zero when empty
//               count/full/empty- occupancy status, all registered-derived
// Revision    : 1.0 - initial release
// ============================================================================
module dec_fifo2 #(
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == 2'd2);
  assign empty     = (r_count == 2'd0);
  assign count     = r_count;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty buffer presents zeros rather than whatever stale entry the read
  // pointer happens to address.
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule : dec_fifo2
`default_nettype wire

// File: rtl/dec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dec_pipe
// Description : Streaming decrement engine. Each accepted operand yields
//               (in_data - in_step) with a borrow flag, in wrap or saturate
//               mode, buffered in a 2-entry output FIFO (latency 1 cycle).
// Ports       : clk, rst_n (async active-low)
//               mode_wr/mode_sat       - mode register load
//               in_valid/in_ready/in_data/in_step - operand handshake
//               out_valid/out_ready/out_data/out_borrow - result handshake
//               mode_q                 - current mode register
// Revision    : 1.0 - initial release
// ============================================================================
module dec_pipe
  import dec_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned DEPTH       = 2,
  parameter logic        SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_wr,
  input  logic             mode_sat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_step,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow,
  output logic             mode_q
);

  generate
    if (DEPTH != 2) begin : g_bad_depth
      $error("dec_pipe: DEPTH must be 2");
    end
    if ((WIDTH < 1) || (WIDTH > DEC_MAX_W)) begin : g_bad_width
      $error("dec_pipe: WIDTH out of range");
    end
  endgenerate

  logic                 r_mode;
  logic [DEC_MAX_W-1:0] w_data_ext;
  logic [DEC_MAX_W-1:0] w_step_ext;
  logic [DEC_MAX_W:0]   w_calc;
  logic [WIDTH:0]       w_entry;
  logic [WIDTH:0]       w_head;
  logic [1:0]           w_count;
  logic                 w_empty;
  logic                 w_unused_full;
  logic                 w_push;
  logic                 w_pop;

  // The register update and the accept share an edge, so an accept in the
  // same cycle as mode_wr still computes with the old mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= SAT_DEFAULT;
    end else if (mode_wr) begin
      r_mode <= mode_sat;
    end
  end

  assign mode_q     = r_mode;
  assign w_data_ext = DEC_MAX_W'(in_data);
  assign w_step_ext = DEC_MAX_W'(in_step);
  assign w_calc     = dec_calc(w_data_ext, w_step_ext, WIDTH, r_mode);
  assign w_entry    = {w_calc[DEC_MAX_W], w_calc[WIDTH-1:0]};

  generate
    if (WIDTH < DEC_MAX_W) begin : g_hi_bits
      // Upper result bits are always zero for this width.
      logic w_unused_hi;
      assign w_unused_hi = ^w_calc[DEC_MAX_W-1:WIDTH];
    end
  endgenerate

  // in_ready looks only at the registered count: no out_ready -> in_ready path.
  assign in_ready  = (w_count < 2'd2);
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  dec_fifo2 #(
    .DW (WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count),
    .full      (w_unused_full),
    .empty     (w_empty)
  );

  assign out_borrow = w_head[WIDTH];
  assign out_data   = w_head[WIDTH-1:0];

endmodule : dec_pipe
`default_nettype wire

// File: tb/tb_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_pipe
// Description : Self-checking bench for dec_pipe. An 8-bit instance runs
//               directed and random traffic against a queue-based model;
//               2-bit and 4-bit instances cover the legacy truth table and
//               the step edge cases with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- 8-bit instance ----------------
  logic       mode_wr8 = 0, mode_sat8 = 0, in_valid8 = 0, out_ready8 = 0;
  logic [7:0] in_data8 = 0, in_step8 = 0;
  logic       in_ready8, out_valid8, out_borrow8, mode_q8;
  logic [7:0] out_data8;

  dec_pipe #(.WIDTH(8), .DEPTH(2), .SAT_DEFAULT(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .mode_wr(mode_wr8), .mode_sat(mode_sat8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_step(in_step8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_borrow(out_borrow8), .mode_q(mode_q8)
  );

  // ---------------- 2-bit instance ----------------
  logic       mode_wr2 = 0, mode_sat2 = 0, in_valid2 = 0, out_ready2 = 0;
  logic [1:0] in_data2 = 0, in_step2 = 0;
  logic       in_ready2, out_valid2, out_borrow2, mode_q2;
  logic [1:0] out_data2;

  dec_pipe #(.WIDTH(2), .DEPTH(2), .SAT_DEFAULT(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mode_wr(mode_wr2), .mode_sat(mode_sat2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_step(in_step2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_borrow(out_borrow2), .mode_q(mode_q2)
  );

  // ---------------- 4-bit instance (saturate after reset) ----------------
  logic       mode_wr4 = 0, mode_sat4 = 0, in_valid4 = 0, out_ready4 = 0;
  logic [3:0] in_data4 = 0, in_step4 = 0;
  logic       in_ready4, out_valid4, out_borrow4, mode_q4;
  logic [3:0] out_data4;

  dec_pipe #(.WIDTH(4), .DEPTH(2), .SAT_DEFAULT(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode_wr(mode_wr4), .mode_sat(mode_sat4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_step(in_step4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_borrow(out_borrow4), .mode_q(mode_q4)
  );

  // ---------------- reference model for the 8-bit instance ----------------
  typedef struct packed {
    logic       b;
    logic [7:0] d;
  } ent_t;

  ent_t mq[$];
  logic m_mode = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int   diff;
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_mode <= 1'b0;
    end else begin
      do_pop  = (mq.size() > 0) && out_ready8;
      do_push = in_valid8 && (mq.size() < 2);
      e = '0;
      if (do_push) begin
        diff = int'(in_data8) - int'(in_step8);
        e.b  = (diff < 0);
        if (diff < 0) diff = m_mode ? 0 : diff + 256;
        e.d  = 8'(diff);
      end
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      if (mode_wr8) m_mode <= mode_sat8;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    cmp("m_out_valid", 32'(out_valid8), 32'(mq.size() > 0));
    cmp("m_in_ready", 32'(in_ready8), 32'(mq.size() < 2));
    cmp("m_out_data", 32'(out_data8), 32'(h.d));
    cmp("m_out_borrow", 32'(out_borrow8), 32'(h.b));
    cmp("m_mode_q", 32'(mode_q8), 32'(m_mode));
  end

  logic [2:0] exp1 [4];

  initial begin
    exp1[0] = 3'b111; exp1[1] = 3'b000; exp1[2] = 3'b001; exp1[3] = 3'b010;

    // Reset state
    repeat (2) @(negedge clk);
    cmp("rst_mode_q8", 32'(mode_q8), 32'd0);
    cmp("rst_mode_q4", 32'(mode_q4), 32'd1);
    cmp("rst_mode_q2", 32'(mode_q2), 32'd0);
    cmp("rst_in_ready8", 32'(in_ready8), 32'd1);
    cmp("rst_in_ready2", 32'(in_ready2), 32'd1);
    cmp("rst_in_ready4", 32'(in_ready4), 32'd1);
    cmp("rst_out_valid8", 32'(out_valid8), 32'd0);
    cmp("rst_out_data8", 32'(out_data8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legacy 2-bit decrement truth table
    out_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1; in_data2 = 2'(i); in_step2 = 2'd1;
      @(negedge clk);
      cmp("t1_valid", 32'(out_valid2), 32'd1);
      cmp("t1_result", 32'({out_borrow2, out_data2}), 32'(exp1[i]));
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    cmp("t1_drain_valid", 32'(out_valid2), 32'd0);
    cmp("t1_drain_data", 32'({out_borrow2, out_data2}), 32'd0);

    // 4-bit step edge cases, including mode_wr coinciding with an accept
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; in_data4 = 4'hF; in_step4 = 4'h0;
    @(negedge clk);
    cmp("t6_sat_step0", 32'({out_borrow4, out_data4}), 32'h0F);
    in_data4 = 4'h0; in_step4 = 4'hF; mode_wr4 = 1'b1; mode_sat4 = 1'b0;
    @(negedge clk);
    mode_wr4 = 1'b0;
    cmp("t6_sat_under", 32'({out_borrow4, out_data4}), 32'h10);
    cmp("t6_mode_q4", 32'(mode_q4), 32'd0);
    @(negedge clk);
    cmp("t6_wrap_under", 32'({out_borrow4, out_data4}), 32'h11);
    in_data4 = 4'hF; in_step4 = 4'h0;
    @(negedge clk);
    cmp("t6_wrap_step0", 32'({out_borrow4, out_data4}), 32'h0F);
    cmp("t6_valid4", 32'(out_valid4), 32'd1);
    in_valid4 = 1'b0;

    // Saturate on the 8-bit instance; second accept overlaps a pop at count 1
    out_ready8 = 1'b1;
    mode_wr8 = 1'b1; mode_sat8 = 1'b1;
    @(negedge clk);
    mode_wr8 = 1'b0;
    cmp("t2_mode_q", 32'(mode_q8), 32'd1);
    in_valid8 = 1'b1; in_data8 = 8'd5; in_step8 = 8'd7;
    @(negedge clk);
    cmp("t2_sat_valid", 32'(out_valid8), 32'd1);
    cmp("t2_sat_result", 32'({out_borrow8, out_data8}), 32'h100);
    in_data8 = 8'd200;
    @(negedge clk);
    cmp("t4_valid_kept", 32'(out_valid8), 32'd1);
    cmp("t2_ok_result", 32'({out_borrow8, out_data8}), 32'd193);
    in_valid8 = 1'b0;
    @(negedge clk);
    cmp("t2_drained", 32'(out_valid8), 32'd0);

    // Backpressure: two accepted, third waits for space
    mode_wr8 = 1'b1; mode_sat8 = 1'b0; out_ready8 = 1'b0;
    in_valid8 = 1'b1; in_data8 = 8'd10; in_step8 = 8'd1;
    @(negedge clk);
    mode_wr8 = 1'b0;
    in_data8 = 8'd20;
    @(negedge clk);
    cmp("t3_full", 32'(in_ready8), 32'd0);
    in_data8 = 8'd30;
    repeat (3) @(negedge clk);
    cmp("t3_stall_ready", 32'(in_ready8), 32'd0);
    cmp("t3_stall_head", 32'(out_data8), 32'd9);
    out_ready8 = 1'b1;
    @(negedge clk);
    cmp("t3_head19", 32'(out_data8), 32'd19);
    cmp("t3_ready_back", 32'(in_ready8), 32'd1);
    @(negedge clk);
    cmp("t3_head29", 32'(out_data8), 32'd29);
    in_valid8 = 1'b0;
    @(negedge clk);
    cmp("t3_drained", 32'(out_valid8), 32'd0);

    // Reset with two entries buffered
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; in_data8 = 8'd50; in_step8 = 8'd3;
    @(negedge clk);
    in_data8 = 8'd60;
    @(negedge clk);
    in_valid8 = 1'b0;
    cmp("t5_pre_valid", 32'(out_valid8), 32'd1);
    cmp("t5_pre_ready", 32'(in_ready8), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    cmp("t5_rst_valid", 32'(out_valid8), 32'd0);
    cmp("t5_rst_ready", 32'(in_ready8), 32'd1);
    cmp("t5_rst_data", 32'({out_borrow8, out_data8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      cmp("t5_no_stale", 32'(out_valid8), 32'd0);
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid8  = ($urandom_range(0, 3) != 0);
      in_data8   = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       in_step8 = 8'd0;
        1:       in_step8 = 8'($urandom_range(0, 3));
        default: in_step8 = 8'($urandom);
      endcase
      out_ready8 = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      mode_wr8   = ($urandom_range(0, 15) == 0);
      mode_sat8  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid8 = 1'b0; mode_wr8 = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dec_pipe
`default_nettype wire
